// File: rtl/dp_memory.sv
// Dual-port register-file memory: one write port, one registered read port with
// write-through forwarding on same-address collisions and synchronous clear.
module dp_memory #(
  parameter int DATA_SIZE  = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] r_addr,
  input  logic [DATA_SIZE-1:0]  w_data,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  output logic [DATA_SIZE-1:0]  r_data,
  output logic                  ready
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_SIZE-1:0] mem_r [DEPTH];
  logic                 wr_en_s;
  logic                 rd_en_s;
  logic                 fwd_s;

  // Qualify enables with valid so an unknown we/re can never reach the state.
  always_comb begin
    wr_en_s = 1'b0;
    rd_en_s = 1'b0;
    fwd_s   = 1'b0;
    if (valid) begin
      wr_en_s = we;
      rd_en_s = re;
    end else begin
      wr_en_s = 1'b0;
      rd_en_s = 1'b0;
    end
    if (wr_en_s && (w_addr == r_addr)) begin
      fwd_s = 1'b1;
    end else begin
      fwd_s = 1'b0;
    end
  end

  // Storage array: cleared as a whole on reset, one word written per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_r <= '{default: {DATA_SIZE{1'b0}}};
    end else if (wr_en_s) begin
      mem_r[w_addr] <= w_data;
    end
  end

  // Read register and its one-cycle ready strobe; data holds when no read is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= {DATA_SIZE{1'b0}};
      ready  <= 1'b0;
    end else begin
      ready <= rd_en_s;
      if (rd_en_s) begin
        r_data <= fwd_s ? w_data : mem_r[r_addr];
      end
    end
  end

endmodule

// File: tb/tb_dp_memory.sv
// Table-driven self-checking bench for dp_memory with directed vectors
// and a hand-written sequence for X-valued enables under valid=0.
module tb_dp_memory;

  typedef struct {
    logic        rst;
    logic        valid;
    logic        we;
    logic        re;
    logic [3:0]  r_addr;
    logic [3:0]  w_addr;
    logic [31:0] w_data;
    logic [31:0] exp_data;
    logic        exp_ready;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, valid, we, re;
  logic [3:0]  r_addr, w_addr;
  logic [31:0] w_data, r_data;
  logic        ready;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  dp_memory #(.DATA_SIZE(32), .ADDR_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .valid(valid), .we(we), .re(re),
    .r_addr(r_addr), .w_data(w_data), .w_addr(w_addr),
    .r_data(r_data), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic v, input logic w, input logic rd,
                     input logic [3:0] ra, input logic [3:0] wa, input logic [31:0] wd,
                     input logic [31:0] ed, input logic er);
    vec_t t;
    t.rst = r; t.valid = v; t.we = w; t.re = rd;
    t.r_addr = ra; t.w_addr = wa; t.w_data = wd;
    t.exp_data = ed; t.exp_ready = er;
    vecs.push_back(t);
  endtask

  task automatic run_table(input string tag);
    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      rst = vecs[k].rst; valid = vecs[k].valid; we = vecs[k].we; re = vecs[k].re;
      r_addr = vecs[k].r_addr; w_addr = vecs[k].w_addr; w_data = vecs[k].w_data;
      @(posedge clk);
      #1;
      check($sformatf("%s[%0d] r_data", tag, k), r_data, vecs[k].exp_data);
      check($sformatf("%s[%0d] ready", tag, k), {31'b0, ready}, {31'b0, vecs[k].exp_ready});
    end
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; we = 1'b0; re = 1'b0;
    r_addr = 4'd0; w_addr = 4'd0; w_data = 32'h0;

    // Reset for two edges, then read of an unwritten address.
    add(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 32'h0, 32'h0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 32'h0, 32'h0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 4'd5, 4'd0, 32'h0, 32'h0, 1'b1);
    for (int i = 0; i < 16; i++)
      add(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'(i), 32'hA000_0000 + 32'(i), 32'h0, 1'b0);
    for (int i = 0; i < 16; i++)
      add(1'b0, 1'b1, 1'b0, 1'b1, 4'(i), 4'd0, 32'h0, 32'hA000_0000 + 32'(i), 1'b1);
    add(1'b0, 1'b1, 1'b1, 1'b1, 4'd3, 4'd3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
    add(1'b0, 1'b1, 1'b0, 1'b1, 4'd3, 4'd0, 32'h0, 32'hDEAD_BEEF, 1'b1);
    add(1'b0, 1'b1, 1'b1, 1'b1, 4'd2, 4'd7, 32'h1234_5678, 32'hA000_0002, 1'b1);
    add(1'b0, 1'b1, 1'b0, 1'b1, 4'd7, 4'd0, 32'h0, 32'h1234_5678, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b1, 4'd4, 4'd4, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 4'd4, 4'd0, 32'h0, 32'hA000_0004, 1'b1);
    run_table("main");

    // valid=0 with unknown enables must leave memory and outputs untouched.
    @(negedge clk);
    valid = 1'b0; we = 1'bx; re = 1'bx;
    r_addr = 4'd4; w_addr = 4'd4; w_data = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    check("xgate r_data", r_data, 32'hA000_0004);
    check("xgate ready", {31'b0, ready}, 32'h0);
    check("xgate no_x", {31'b0, $isunknown(r_data)}, 32'h0);
    @(negedge clk);
    valid = 1'b1; we = 1'b0; re = 1'b1; r_addr = 4'd4;
    @(posedge clk);
    #1;
    check("xgate readback", r_data, 32'hA000_0004);

    // Reset on the same edge as a read of a filled word, then read-back after clear.
    vecs.delete();
    add(1'b1, 1'b1, 1'b0, 1'b1, 4'd9, 4'd0, 32'h0, 32'h0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 4'd9, 4'd0, 32'h0, 32'h0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 1'b1, 4'd3, 4'd0, 32'h0, 32'h0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 32'h0, 32'h0, 1'b0);
    run_table("rst_op");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
